vga_timing_generator: RTL and testbench
=======================================

// Module: vga_timing_generator
// PURPOSE
//   Generates 640x480@60Hz VGA timing: pixel-rate tick, horizontal/vertical position
//   counters, active-low hsync/vsync, and a video_on flag. It is the source of the
//   pixel_x/pixel_y/video_on stream that the image pixel controller consumes to fetch
//   pixel colour, and it drives the sync pins directly.
// PARAMETERS
//   CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz pixel rate); >=1
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   reset        in   1   synchronous, active-high reset
//   p_tick       out  1   one-clk pulse every CLK_DIV clks; the position advances on it
//   pixel_x      out  10  current horizontal position, 0..H_TOTAL-1
//   pixel_y      out  10  current vertical position, 0..V_TOTAL-1
//   video_on     out  1   1 when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
//   hsync        out  1   active-low horizontal sync
//   vsync        out  1   active-low vertical sync
//   frame_start  out  1   one-clk pulse in the clk the position becomes (0,0)
// BEHAVIOUR
//   - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = sum of V terms (525).
//   - Tick divider: counter div 0..CLK_DIV-1, +1 every clk, wraps to 0.
//     p_tick = (div == CLK_DIV-1), combinational from the register. With CLK_DIV=1,
//     p_tick is constantly 1.
//   - Position: on each clk with p_tick=1, h = (h==H_TOTAL-1) ? 0 : h+1. When h wraps,
//     v = (v==V_TOTAL-1) ? 0 : v+1. No change without p_tick.
//   - hsync, vsync, video_on, and frame_start are registered. They are computed from the
//     next h/v values, so they change in the same clk as pixel_x/pixel_y and all outputs
//     are mutually aligned (zero relative latency).
//   - hsync = 0 iff H_DISPLAY+H_FRONT <= h <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
//   - vsync = 0 iff V_DISPLAY+V_FRONT <= v <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
//   - frame_start = 1 for exactly the one clk in which (h,v) is updated to (0,0).
//   - Reset state (held while reset=1): div=0, pixel_x=H_TOTAL-1 (799),
//     pixel_y=V_TOTAL-1 (524), video_on=0, hsync=1, vsync=1, frame_start=0.
//     The first p_tick after release therefore moves to (0,0) and fires frame_start.
//   - Reset mid-operation: takes effect at the next clk edge regardless of div/h/v.
//     The sync outputs go directly to 1 with no intermediate value.
//   - pixel_x/pixel_y are never >= H_TOTAL/V_TOTAL. Arithmetic is unsigned, 10 bits,
//     no overflow. The block elaborates correctly with any parameter set whose totals
//     are <= 1024.
// TESTING
//   1. Hold reset for 3 clks -> pixel_x=799, pixel_y=524, hsync=1, vsync=1, video_on=0,
//      frame_start=0, p_tick=0.
//   2. Release reset -> p_tick is high in the 4th clk. On that edge: (0,0), video_on=1,
//      frame_start pulses for 1 clk. p_tick then recurs every 4 clks.
//   3. Line sweep: 639->640 video_on 1->0; 655->656 hsync 1->0; 751->752 hsync 0->1;
//      799->0 pixel_y increments by 1 on the same edge.
//   4. Frame sweep: pixel_y 489->490 vsync 1->0; 491->492 vsync 0->1; (799,524)->(0,0)
//      fires frame_start. Exactly 1,680,000 clks between successive frame_start pulses.
//   5. Assert reset for 1 clk at (300,200) with div=2 -> next clk is the full reset state.
//      After release, the first frame_start comes 4 clks later.
//   6. CLK_DIV=1 build -> p_tick stays 1; 420,000 clks per frame; sync positions as in 3/4.

Source files
------------

// File: rtl/vga_timing_generator.sv
// vga_timing_generator
//   VGA raster timing source (640x480@60Hz by default). Divides the system clock
//   down to a pixel tick and sweeps the horizontal/vertical position across the full
//   line/frame totals. It also produces active-low hsync/vsync, video_on and a one-clk
//   frame_start pulse.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   p_tick       one-clk pulse every CLK_DIV clks; the position advances on it
//   pixel_x      horizontal position, 0..H_TOTAL-1
//   pixel_y      vertical position, 0..V_TOTAL-1
//   video_on     1 inside the visible H_DISPLAY x V_DISPLAY area
//   hsync/vsync  active-low sync pulses
//   frame_start  one-clk pulse in the clk the position becomes (0,0)
module vga_timing_generator #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]       V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div, div_next;
  logic [9:0]       h, v, h_next, v_next;
  logic             video_on_next, hsync_next, vsync_next, frame_start_next;

  assign p_tick  = (div == DIV_MAX);
  assign pixel_x = h;
  assign pixel_y = v;

  // Decoded outputs are derived from the next position and registered alongside it,
  // so every output changes on the same edge as pixel_x/pixel_y.
  always_comb begin
    div_next = div + 1'b1;
    h_next   = h;
    v_next   = v;
    if (p_tick) begin
      div_next = '0;
      if (h == H_MAX) begin
        h_next = '0;
        v_next = (v == V_MAX) ? '0 : v + 1'b1;
      end else begin
        h_next = h + 1'b1;
      end
    end
    video_on_next    = (h_next < H_VIS) && (v_next < V_VIS);
    hsync_next       = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
    vsync_next       = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    frame_start_next = p_tick && (h_next == '0) && (v_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h           <= H_MAX;
      v           <= V_MAX;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      h           <= h_next;
      v           <= v_next;
      video_on    <= video_on_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default 640x480 instance plus two reduced-geometry
// instances (CLK_DIV=3 and CLK_DIV=1) so whole frames fit in a short run. Expected
// outputs come from the clk count since reset release, turned into a linear raster
// position with plain division/modulo.
module tb_vga_timing_generator;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       p0, vo0, hs0, vs0, fs0;
  logic [9:0] x0, y0;
  logic       p1, vo1, hs1, vs1, fs1;
  logic [9:0] x1, y1;
  logic       p2, vo2, hs2, vs2, fs2;
  logic [9:0] x2, y2;

  vga_timing_generator dut_full (
    .clk(clk), .reset(reset), .p_tick(p0), .pixel_x(x0), .pixel_y(y0),
    .video_on(vo0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
  );

  vga_timing_generator #(
    .CLK_DIV(3), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_small (
    .clk(clk), .reset(reset), .p_tick(p1), .pixel_x(x1), .pixel_y(y1),
    .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  vga_timing_generator #(
    .CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_div1 (
    .clk(clk), .reset(reset), .p_tick(p2), .pixel_x(x2), .pixel_y(y2),
    .video_on(vo2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;
  int last1 = -1;
  int last2 = -1;

  // n = rising edges since the last edge that sampled reset high.
  function automatic exp_t model(input int cnt, input int cd,
                                 input int hd, input int hf, input int hs, input int hb,
                                 input int vd, input int vf, input int vs, input int vb);
    exp_t e;
    int ht, vt, ticks, pos, h, v;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    ticks = cnt / cd;
    pos = (ht * vt - 1 + ticks) % (ht * vt);
    h = pos % ht;
    v = pos / ht;
    e.p_tick      = ((cnt % cd) == cd - 1);
    e.x           = 10'(h);
    e.y           = 10'(v);
    e.video_on    = (h < hd) && (v < vd);
    e.hsync       = !((h >= hd + hf) && (h < hd + hf + hs));
    e.vsync       = !((v >= vd + vf) && (v < vd + vf + vs));
    e.frame_start = (cnt > 0) && ((cnt % cd) == 0) && (pos == 0);
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b expected tick=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
             tag, n, obs.p_tick, obs.x, obs.y, obs.video_on, obs.hsync, obs.vsync, obs.frame_start,
             exp.p_tick, exp.x, exp.y, exp.video_on, exp.hsync, exp.vsync, exp.frame_start);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  task automatic cycle(input logic r);
    exp_t o;
    reset = r;
    @(posedge clk);
    n = r ? 0 : n + 1;
    @(negedge clk);
    o = {p0, x0, y0, vo0, hs0, vs0, fs0};
    check_out("full", o, model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    o = {p1, x1, y1, vo1, hs1, vs1, fs1};
    check_out("small", o, model(n, 3, 20, 3, 5, 4, 12, 2, 2, 3));
    o = {p2, x2, y2, vo2, hs2, vs2, fs2};
    check_out("div1", o, model(n, 1, 20, 3, 5, 4, 12, 2, 2, 3));
    if (r) begin
      last1 = -1;
      last2 = -1;
    end
    if (fs1) begin
      if (last1 >= 0) check_int("frame_period_small", n - last1, 3 * 32 * 19);
      last1 = n;
    end
    if (fs2) begin
      if (last2 >= 0) check_int("frame_period_div1", n - last2, 32 * 19);
      last2 = n;
    end
  endtask

  initial begin
    int rlen, run;
    // Reset held 3 clks, then a long run: two full lines of the default geometry and
    // several complete frames of the reduced ones.
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 7000; i++) cycle(1'b0);
    // Reset pulses dropped at random points in the raster and divider phase.
    for (int s = 0; s < 8; s++) begin
      rlen = int'($urandom_range(1, 3));
      run  = int'($urandom_range(40, 2500));
      for (int i = 0; i < rlen; i++) cycle(1'b1);
      for (int i = 0; i < run; i++) cycle(1'b0);
    end
    // Single-clk reset at a position reached with divider phase 2 on the default build.
    for (int i = 0; i < 6; i++) cycle(1'b0);
    while ((n % 4) != 2) cycle(1'b0);
    cycle(1'b1);
    for (int i = 0; i < 4000; i++) cycle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
